// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared FSM encodings, requester count and one-hot helper
package mux4_rr_arbiter_pkg;
  localparam int NUM_REQ = 4;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker starting the scan just after last
//   req   : candidate request bits
//   last  : index of the most recent owner
//   found : some candidate bit was set
//   idx   : first set index in order last+1 .. last+4 (mod 4)
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               found,
  output logic [1:0]         idx
);
  always_comb begin
    found = |req;
    idx   = '0;
    // scan from furthest to nearest so the nearest hit is the one kept
    for (int i = NUM_REQ; i >= 1; i--)
      if (req[last + 2'(i)]) idx = last + 2'(i);
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner control for a 4-to-1 mux with burst limit
//   clock : system clock
//   reset : synchronous active-high reset
//   req   : request vector, req[k] asks for mux input k
//   gnt   : registered one-hot grant, zero when idle
//   sel   : registered mux select {s1,s0}, holds its value while idle
//   busy  : registered, high while a grant is active
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               busy
);
  state_t             state, state_nx;
  logic [CNT_W-1:0]   hold_cnt, hold_nx;
  logic [1:0]         last, last_nx, sel_nx, pick_last, idx;
  logic [NUM_REQ-1:0] gnt_nx, cand;
  logic               busy_nx, found, granted, rel;
  assign granted   = state == ST_GRANT;
  assign rel       = !req[sel] || hold_cnt == CNT_W'(MAX_HOLD - 1);
  // while granted the owner is treated as last so rotation starts after it
  assign pick_last = granted ? sel : last;
  // a voluntary release keeps the owner out; on expiry it competes last
  assign cand      = (granted && !req[sel]) ? req & ~onehot(sel) : req;
  rr_pick4 u_pick (
    .req   (cand),
    .last  (pick_last),
    .found (found),
    .idx   (idx)
  );
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    last_nx  = last;
    sel_nx   = sel;
    gnt_nx   = gnt;
    busy_nx  = busy;
    if (granted && !rel) begin
      hold_nx = hold_cnt + CNT_W'(1);
    end else if (found) begin
      state_nx = ST_GRANT;
      hold_nx  = '0;
      last_nx  = pick_last;
      sel_nx   = idx;
      gnt_nx   = onehot(idx);
      busy_nx  = 1'b1;
    end else if (granted) begin
      state_nx = ST_IDLE;
      hold_nx  = '0;
      last_nx  = sel;
      gnt_nx   = '0;
      busy_nx  = 1'b0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      last     <= 2'd3;
      sel      <= 2'd0;
      gnt      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      last     <= last_nx;
      sel      <= sel_nx;
      gnt      <= gnt_nx;
      busy     <= busy_nx;
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: randomized and directed check of mux4_rr_arbiter against a behavioural model
module tb_mux4_rr_arbiter;
  localparam int MAX_HOLD = 4;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  int n_chk  = 0;
  int n_pass = 0;
  int owner  = -1;
  int owned  = 0;
  int last_m = 3;
  int sel_m  = 0;
  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask
  function automatic int pick(input logic [3:0] r, input int from);
    for (int i = 1; i <= 4; i++)
      if (r[(from + i) % 4]) return (from + i) % 4;
    return -1;
  endfunction
  task automatic model(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      owner = -1; owned = 0; last_m = 3; sel_m = 0;
    end else if (owner < 0) begin
      w = pick(r, last_m);
      if (w >= 0) begin owner = w; owned = 1; sel_m = w; end
    end else if (r[owner] && owned < MAX_HOLD) begin
      owned++;
    end else begin
      last_m = owner;
      w = pick(r[owner] ? r : r & ~(4'b0001 << owner), owner);
      owner = w;
      owned = (w >= 0) ? 1 : 0;
      if (w >= 0) sel_m = w;
    end
  endtask
  task automatic cycle(input logic [3:0] r, input logic rs);
    req = r;
    reset = rs;
    @(posedge clock);
    model(r, rs);
    @(negedge clock);
    chk("gnt",  {4'b0, gnt},  {4'b0, (owner < 0) ? 4'b0000 : 4'(4'b0001 << owner)});
    chk("sel",  {6'b0, sel},  8'(sel_m));
    chk("busy", {7'b0, busy}, {7'b0, owner >= 0});
  endtask
  initial begin
    logic [3:0] r;
    @(negedge clock);
    repeat (2) cycle(4'b1111, 1'b1);
    repeat (20) cycle(4'b1111, 1'b0);
    repeat (10) cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0011, 1'b0);
    cycle(4'b0011, 1'b0);
    cycle(4'b0010, 1'b0);
    chk("drop_to_1", {4'b0, gnt}, 8'h02);
    repeat (3) cycle(4'b0000, 1'b0);
    cycle(4'b0101, 1'b1);
    cycle(4'b0101, 1'b0);
    chk("post_reset_first", {4'b0, gnt}, 8'h01);
    cycle(4'b1000, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    chk("idle_sel_hold", {6'b0, sel}, 8'h03);
    cycle(4'b1001, 1'b0);
    chk("after3_rotate", {4'b0, gnt}, 8'h01);
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cycle(r, $urandom_range(0, 99) < 2);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter/controller that shares the 4-to-1 multiplexer between four requesters. It decides which input (i0..i3) the mux passes, drives the mux select lines s1/s0, and returns one-hot grants. Each grant has a bounded hold time (burst limit) so no requester can starve the others. It sits directly in front of mux4_to_1, whose s1/s0 inputs take this block's sel[1]/sel[0].

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant; legal range 1..2**CNT_W
CNT_W, 3, width of the hold counter

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req    input  4  request vector; req[k] asks for mux input ik
gnt    output 4  one-hot grant, registered; 4'b0000 when nobody owns the mux
sel    output 2  registered mux select {s1,s0}; equals the owner index while granted
busy   output 1  registered; 1 while any grant is active

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`. Reset overrides all other inputs at the edge where it is sampled.
- Reset values: gnt=0000, sel=00, busy=0, state=IDLE, hold_cnt=0, last=2'd3. last=3 gives requester 0 first priority after reset.
- States:
  - IDLE: no owner.
  - GRANT: owner = sel; gnt = 1<<sel.
- Pick function (combinational): scan order last+1, last+2, last+3, last+4 (mod 4). Return the first index k with the candidate request bit set. "none" if all candidate bits are 0.
- IDLE transitions:
  - If |req, pick over req and go to GRANT next edge.
  - gnt = one-hot(pick), sel = pick, busy = 1, hold_cnt = 0.
  - Latency: req to gnt is exactly 1 cycle.
- GRANT, each cycle, with owner o:
  - Release condition: req[o]==0 OR hold_cnt==MAX_HOLD-1.
  - If not releasing: hold_cnt increments, outputs are unchanged.
  - On release: last <= o, and pick runs with last treated as o on the same edge.
  - Candidate set on release:
    - Voluntary release (req[o]==0): req with bit o masked.
    - Expiry: full req, so the owner competes last in rotation.
  - If pick finds a winner: grant switches on that same edge with no idle bubble, and hold_cnt <= 0.
  - If pick finds none: go to IDLE. gnt=0000, busy=0, and sel holds its last value.
- Expiry with only the owner still requesting: the owner is re-granted on the same edge. gnt stays high continuously and hold_cnt restarts at 0.
- MAX_HOLD=1: hold_cnt==0 always releases, so grants rotate every cycle among active requesters.
- Req is not sticky. A requester that deasserts before being granted loses its turn.
- gnt is never more than one-hot. sel and gnt always agree while busy=1.
- Reset mid-grant: the next edge returns every output to its reset value. Any pending state is discarded.
- hold_cnt is never greater than MAX_HOLD-1 and never wraps.

Decomposition:
- Shared include/package: state encodings (ST_IDLE=1'b0, ST_GRANT=1'b1) and the NUM_REQ=4 constant.
- Sub-module rr_pick4: purely combinational round-robin picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: found, idx[1:0].
  - The top module instantiates it once and feeds it masked or unmasked req.
- The top module holds only the registers and the FSM.

Test Plan (MAX_HOLD=4):
- Reset with req=1111 held for 2 cycles: gnt=0000, sel=00, busy=0 throughout. On the first cycle after reset falls, gnt=0001, sel=00.
- Steady req=1111 for 20 cycles: gnt=0001 for 4 cycles, then 0010 x4, 0100 x4, 1000 x4, then 0001 again. sel steps 00,01,10,11. No cycle has gnt=0000.
- req=0100 alone for 10 cycles: gnt=0100 and sel=10 from cycle 1. hold_cnt reaches 3 and restarts. gnt stays continuously 0100 across both expiries.
- Owner 0 drops req after 2 granted cycles while req[1]=1: on the next edge gnt=0010, sel=01. There is no idle cycle and owner 0 is not re-granted.
- Reset pulse while owner 2 has hold_cnt=2: next edge gnt=0000, busy=0. With req=0101 afterwards, the first grant is 0001 (last=3).
- All req drop while owner=3: next edge gnt=0000, busy=0, sel stays 11. A later req=1001 grants 0001 (rotation after 3).
